// File: rtl/opc5_mem_arbiter.sv
// Cycle-by-cycle owner arbiter for the OPC5 asynchronous-read RAM: CPU (gated via cpu_clken) versus one DMA requester.
// Define ARB_DMA_BURST_EN to let a DMA grant extend up to MAX_BURST consecutive cycles while dma_req stays high.
module opc5_mem_arbiter #(
  parameter int CPU_MIN_SLOTS = 3,
  parameter int MAX_BURST     = 4
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [15:0] cpu_address,
  input  logic [15:0] cpu_dout,
  input  logic        cpu_rnw,
  output logic [15:0] cpu_din,
  output logic        cpu_clken,
  input  logic        dma_req,
  input  logic        dma_rnw,
  input  logic [15:0] dma_address,
  input  logic [15:0] dma_wdata,
  output logic        dma_ack,
  output logic [15:0] dma_rdata,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [15:0] stolen_cycles
);

  // DMA handshake: dma_req/dma_rnw/dma_address/dma_wdata are held stable until a cycle
  // with dma_ack=1; that transfer completes (write commits, read data captured) at the
  // rising edge closing the cycle. The requester may then present the next transfer.

  if (CPU_MIN_SLOTS < 1 || CPU_MIN_SLOTS > 255) begin : g_bad_min
    $error("CPU_MIN_SLOTS out of range 1..255");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
    $error("MAX_BURST out of range 1..255");
  end

  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;

  localparam logic [7:0] CPU_RELOAD = 8'(CPU_MIN_SLOTS - 1);

  owner_t      owner_q, owner_d;
  logic [7:0]  cpu_cnt_q, cpu_cnt_d;
  logic [15:0] stolen_q;

`ifdef ARB_DMA_BURST_EN
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  logic [7:0] burst_cnt_q, burst_cnt_d;
`endif

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      owner_q   <= OWN_CPU;
      cpu_cnt_q <= CPU_RELOAD;
      stolen_q  <= '0;
`ifdef ARB_DMA_BURST_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      owner_q   <= owner_d;
      cpu_cnt_q <= cpu_cnt_d;
      if (owner_q == OWN_DMA) stolen_q <= stolen_q + 16'd1;
`ifdef ARB_DMA_BURST_EN
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

  // Ownership decision uses only registered state plus dma_req sampled at the edge.
  always_comb begin
    owner_d   = owner_q;
    cpu_cnt_d = cpu_cnt_q;
`ifdef ARB_DMA_BURST_EN
    burst_cnt_d = burst_cnt_q;
`endif
    if (owner_q == OWN_CPU) begin
      if (cpu_cnt_q != 8'd0) begin
        cpu_cnt_d = cpu_cnt_q - 8'd1;
      end else if (dma_req) begin
        owner_d = OWN_DMA;
`ifdef ARB_DMA_BURST_EN
        burst_cnt_d = '0;
`endif
      end
    end else begin
`ifdef ARB_DMA_BURST_EN
      if (dma_req && (burst_cnt_q < BURST_LAST)) begin
        burst_cnt_d = burst_cnt_q + 8'd1;
      end else begin
        owner_d   = OWN_CPU;
        cpu_cnt_d = CPU_RELOAD;
      end
`else
      owner_d   = OWN_CPU;
      cpu_cnt_d = CPU_RELOAD;
`endif
    end
  end

  // Reset overrides are combinational so a burst cut by reset never commits a write.
  always_comb begin
    cpu_clken   = 1'b1;
    dma_ack     = 1'b0;
    mem_address = cpu_address;
    mem_wdata   = cpu_dout;
    mem_we      = !cpu_rnw;
    if (owner_q == OWN_DMA) begin
      cpu_clken   = 1'b0;
      dma_ack     = dma_req;
      mem_address = dma_address;
      mem_wdata   = dma_wdata;
      mem_we      = dma_req & !dma_rnw;
    end
    if (!reset_b) begin
      cpu_clken = 1'b1;
      dma_ack   = 1'b0;
      mem_we    = 1'b0;
    end
  end

  assign cpu_din       = mem_rdata;
  assign dma_rdata     = mem_rdata;
  assign stolen_cycles = stolen_q;

endmodule
